// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the shared memory bus and the port arbiter.
// The master modport is the arbiter's view; slave is the pipeline/bus side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_busy;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_busy;
    logic                  bus_req;
    logic                  bus_we;
    logic [DATA_W/8-1:0]   bus_be;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output if_rvalid, if_rdata, if_busy,
        output mem_rvalid, mem_rdata, mem_busy,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  if_rvalid, if_rdata, if_busy,
        input  mem_rvalid, mem_rdata, mem_busy,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store: one outstanding
// transaction, MEM priority with bounded IF starvation, flushed fetch responses dropped.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master port
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_MEM_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MEM_BURST);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic       OWN_IF      = 1'b0;
    localparam logic       OWN_MEM     = 1'b1;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              owner_r;
    logic              drop_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [BE_W-1:0]   bus_be_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic              if_elig_s;
    logic              grant_mem_s;
    logic              grant_if_s;
    logic              rsp_s;
    logic              if_rvalid_s;
    logic              mem_rvalid_s;

    // Winner selection in IDLE and per-owner response decode
    always_comb begin
        if_elig_s    = port.if_req & ~port.if_flush;
        grant_mem_s  = 1'b0;
        grant_if_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (port.mem_req && !(if_elig_s && (starve_cnt_r == CNT_MAX))) begin
                grant_mem_s = 1'b1;
            end else if (if_elig_s) begin
                grant_if_s = 1'b1;
            end else begin
                grant_mem_s = 1'b0;
                grant_if_s  = 1'b0;
            end
        end else begin
            grant_mem_s = 1'b0;
            grant_if_s  = 1'b0;
        end
        rsp_s        = (state_r == ST_WAIT_RSP) & port.bus_rvalid;
        if_rvalid_s  = rsp_s & (owner_r == OWN_IF) & ~drop_r & ~port.if_flush;
        mem_rvalid_s = rsp_s & (owner_r == OWN_MEM);
    end

    // Next-state logic for the single-outstanding bus handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_mem_s || grant_if_s) state_nxt_s = ST_WAIT_GNT;
                else                           state_nxt_s = ST_IDLE;
            end
            ST_WAIT_GNT: begin
                if (port.bus_gnt) state_nxt_s = ST_WAIT_RSP;
                else              state_nxt_s = ST_WAIT_GNT;
            end
            ST_WAIT_RSP: begin
                if (port.bus_rvalid) state_nxt_s = ST_IDLE;
                else                 state_nxt_s = ST_WAIT_RSP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, owner and bus request fields; fields stay frozen until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_IF;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_be_r    <= {BE_W{1'b0}};
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_mem_s) begin
                owner_r     <= OWN_MEM;
                bus_req_r   <= 1'b1;
                bus_we_r    <= port.mem_we;
                bus_be_r    <= port.mem_be;
                bus_addr_r  <= port.mem_addr;
                bus_wdata_r <= port.mem_wdata;
            end else if (grant_if_s) begin
                // Fetches are always full-word reads
                owner_r     <= OWN_IF;
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b0;
                bus_be_r    <= {BE_W{1'b1}};
                bus_addr_r  <= port.if_addr;
                bus_wdata_r <= {DATA_W{1'b0}};
            end else if ((state_r == ST_WAIT_GNT) && port.bus_gnt) begin
                bus_req_r <= 1'b0;
            end else begin
                bus_req_r <= bus_req_r;
            end
        end
    end

    // IF starvation counter and flushed-fetch drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
            drop_r       <= 1'b0;
        end else begin
            if (!port.if_req || grant_if_s) begin
                starve_cnt_r <= {CNT_W{1'b0}};
            end else if (grant_mem_s && (starve_cnt_r != CNT_MAX)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            if ((state_r == ST_IDLE) || rsp_s) begin
                drop_r <= 1'b0;
            end else if ((owner_r == OWN_IF) && port.if_flush) begin
                drop_r <= 1'b1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    assign port.bus_req    = bus_req_r;
    assign port.bus_we     = bus_we_r;
    assign port.bus_be     = bus_be_r;
    assign port.bus_addr   = bus_addr_r;
    assign port.bus_wdata  = bus_wdata_r;
    assign port.if_rvalid  = if_rvalid_s;
    assign port.mem_rvalid = mem_rvalid_s;
    assign port.if_rdata   = port.bus_rdata;
    assign port.mem_rdata  = port.bus_rdata;
    assign port.if_busy    = port.if_req & ~if_rvalid_s;
    assign port.mem_busy   = port.mem_req & ~mem_rvalid_s;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked against
// a transaction-level reference model with a bench-driven bus slave.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) pif ();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_BURST(MAXB)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (pif.master)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: at most one transaction in flight, described by these fields
    bit m_has, m_gnt, m_own_mem, m_drop;
    int m_streak;
    logic m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int sl_cnt, sl_gdly, sl_rdly;
    bit sl_rand;
    logic [DW-1:0] sl_rdata;
    bit e_if_rv, e_mem_rv;
    logic o_bus_req, o_if_rv, o_mem_rv, o_brv, o_bus_we;
    logic [BW-1:0] o_bus_be;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_wdata, o_if_rdata;
    bit obs_order[$];
    bit pat[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int mem_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit if_ok, gm, gi;
        if_ok = 1'b0;
        gm    = 1'b0;
        gi    = 1'b0;
        if (rst) begin
            m_has = 1'b0; m_gnt = 1'b0; m_drop = 1'b0; m_own_mem = 1'b0;
            m_streak = 0; sl_cnt = 0;
            return;
        end
        if (m_has) begin
            if (!m_own_mem && pif.if_flush) m_drop = 1'b1;
            if (!m_gnt) begin
                if (pif.bus_gnt) begin m_gnt = 1'b1; sl_cnt = 0; end
                else sl_cnt++;
            end else if (pif.bus_rvalid) begin
                m_has = 1'b0; m_drop = 1'b0;
            end else begin
                sl_cnt++;
            end
        end else begin
            if_ok = pif.if_req && !pif.if_flush;
            gm    = pif.mem_req && !(if_ok && m_streak == MAXB);
            gi    = !gm && if_ok;
            if (gm || gi) begin
                m_has = 1'b1; m_gnt = 1'b0; m_own_mem = gm; sl_cnt = 0;
                m_we    = gm ? pif.mem_we : 1'b0;
                m_be    = gm ? pif.mem_be : {BW{1'b1}};
                m_addr  = gm ? pif.mem_addr : pif.if_addr;
                m_wdata = pif.mem_wdata;
                if (sl_rand) begin
                    sl_gdly = $urandom_range(0, 3);
                    sl_rdly = $urandom_range(0, 3);
                end
            end
        end
        if (!pif.if_req || gi) m_streak = 0;
        else if (gm) m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
    endtask

    // One clock: slave drives, check at negedge, model advances at posedge
    task automatic step();
        pif.bus_gnt    = m_has && !m_gnt && (sl_cnt >= sl_gdly) && !rst;
        pif.bus_rvalid = m_has && m_gnt && (sl_cnt >= sl_rdly) && !rst;
        pif.bus_rdata  = sl_rand ? DW'($urandom) : sl_rdata;
        @(negedge clk);
        e_mem_rv = m_has && m_gnt && pif.bus_rvalid && m_own_mem;
        e_if_rv  = m_has && m_gnt && pif.bus_rvalid && !m_own_mem && !m_drop && !pif.if_flush;
        chk("bus_req", pif.bus_req, m_has && !m_gnt);
        chk("if_rvalid", pif.if_rvalid, e_if_rv);
        chk("mem_rvalid", pif.mem_rvalid, e_mem_rv);
        chk("if_busy", pif.if_busy, pif.if_req && !e_if_rv);
        chk("mem_busy", pif.mem_busy, pif.mem_req && !e_mem_rv);
        if (m_has && !m_gnt) begin
            chk("bus_we", pif.bus_we, m_we);
            chk("bus_be", pif.bus_be, m_be);
            chk("bus_addr", pif.bus_addr, m_addr);
            if (m_own_mem) chk("bus_wdata", pif.bus_wdata, m_wdata);
        end
        if (e_if_rv)  chk("if_rdata", pif.if_rdata, pif.bus_rdata);
        if (e_mem_rv) chk("mem_rdata", pif.mem_rdata, pif.bus_rdata);
        o_bus_req = pif.bus_req;   o_if_rv = pif.if_rvalid;  o_mem_rv = pif.mem_rvalid;
        o_brv = pif.bus_rvalid;    o_bus_we = pif.bus_we;    o_bus_be = pif.bus_be;
        o_bus_addr = pif.bus_addr; o_bus_wdata = pif.bus_wdata; o_if_rdata = pif.if_rdata;
        if (pif.if_rvalid === 1'b1)  obs_order.push_back(1'b0);
        if (pif.mem_rvalid === 1'b1) obs_order.push_back(1'b1);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        pif.if_req = 1'b0;  pif.if_addr = '0;  pif.if_flush = 1'b0;
        pif.mem_req = 1'b0; pif.mem_we = 1'b0; pif.mem_be = '0; pif.mem_addr = '0; pif.mem_wdata = '0;
        pif.bus_gnt = 1'b0; pif.bus_rvalid = 1'b0; pif.bus_rdata = '0;
        sl_rand = 1'b0; sl_gdly = 0; sl_rdly = 0; sl_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        step();
        chk("rst_bus_req", o_bus_req, 1'b0);
        chk("rst_bus_we", o_bus_we, 1'b0);
        chk("rst_bus_be", o_bus_be, 4'h0);
        chk("rst_bus_addr", o_bus_addr, 32'h0);
        chk("rst_bus_wdata", o_bus_wdata, 32'h0);

        // Single fetch: bus_req in cycle 1, if_rvalid with data in cycle 2
        pif.if_req = 1'b1; pif.if_addr = 32'h0000_0100; sl_rdata = 32'h0000_0013;
        step();
        step();
        chk("fetch_bus_req_c1", o_bus_req, 1'b1);
        chk("fetch_bus_addr_c1", o_bus_addr, 32'h0000_0100);
        step();
        chk("fetch_if_rvalid_c2", o_if_rv, 1'b1);
        chk("fetch_if_rdata_c2", o_if_rdata, 32'h0000_0013);
        chk("fetch_mem_rvalid_c2", o_mem_rv, 1'b0);
        pif.if_req = 1'b0;
        step();

        // Simultaneous requests: MEM first, then IF
        obs_order.delete();
        pif.if_req = 1'b1;  pif.if_addr = 32'h0000_0104;
        pif.mem_req = 1'b1; pif.mem_we = 1'b0; pif.mem_be = 4'hF; pif.mem_addr = 32'h0000_2000;
        for (int i = 0; i < 20 && pif.if_req; i++) begin
            step();
            if (e_mem_rv) pif.mem_req = 1'b0;
            if (e_if_rv)  pif.if_req = 1'b0;
        end
        chk("both_count", obs_order.size(), 2);
        if (obs_order.size() >= 2) begin
            chk("both_first_mem", obs_order[0], 1'b1);
            chk("both_second_if", obs_order[1], 1'b0);
        end
        step();

        // Store fields
        pif.mem_req = 1'b1; pif.mem_we = 1'b1; pif.mem_be = 4'b0011;
        pif.mem_addr = 32'h0000_0040; pif.mem_wdata = 32'hDEAD_BEEF;
        step();
        step();
        chk("store_bus_we", o_bus_we, 1'b1);
        chk("store_bus_be", o_bus_be, 4'b0011);
        chk("store_bus_addr", o_bus_addr, 32'h0000_0040);
        chk("store_bus_wdata", o_bus_wdata, 32'hDEAD_BEEF);
        step();
        chk("store_mem_rvalid", o_mem_rv, 1'b1);
        pif.mem_req = 1'b0; pif.mem_we = 1'b0;
        step();

        // Flush while waiting for the response
        pif.if_req = 1'b1; pif.if_addr = 32'h0000_0200; sl_rdly = 2;
        step();
        step();
        pif.if_flush = 1'b1;
        step();
        pif.if_flush = 1'b0; pif.if_req = 1'b0;
        o_brv = 1'b0;
        for (int i = 0; i < 10 && !o_brv; i++) step();
        chk("flush_rsp_seen", o_brv, 1'b1);
        chk("flush_if_rvalid", o_if_rv, 1'b0);
        sl_rdly = 0;

        // Flush coincident with the response
        pif.if_req = 1'b1; pif.if_addr = 32'h0000_0400;
        step();
        step();
        pif.if_flush = 1'b1;
        step();
        chk("coflush_rsp_seen", o_brv, 1'b1);
        chk("coflush_if_rvalid", o_if_rv, 1'b0);
        pif.if_flush = 1'b0; pif.if_req = 1'b0;
        step();

        // Next fetch served normally
        pif.if_req = 1'b1; pif.if_addr = 32'h0000_0500; sl_rdata = 32'h0000_ABCD;
        step();
        step();
        step();
        chk("after_flush_if_rvalid", o_if_rv, 1'b1);
        chk("after_flush_if_rdata", o_if_rdata, 32'h0000_ABCD);
        pif.if_req = 1'b0;
        step();

        // Build up starvation, then reset while waiting for a grant
        pif.if_req = 1'b1; pif.if_addr = 32'h0000_1000;
        pif.mem_req = 1'b1; pif.mem_we = 1'b0; pif.mem_be = 4'hF; pif.mem_addr = 32'h0000_3000;
        mem_done = 0;
        for (int i = 0; i < 30 && mem_done < 2; i++) begin
            step();
            if (e_mem_rv) begin mem_done++; pif.mem_addr += 32'd4; end
        end
        chk("prereset_mem_done", mem_done, 2);
        sl_gdly = 99;
        step();
        step();
        chk("prereset_bus_req", o_bus_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0; sl_gdly = 0;
        obs_order.delete();
        step();
        chk("postrst_bus_req", o_bus_req, 1'b0);
        chk("postrst_bus_addr", o_bus_addr, 32'h0);
        chk("postrst_bus_be", o_bus_be, 4'h0);
        chk("postrst_if_rvalid", o_if_rv, 1'b0);
        chk("postrst_mem_rvalid", o_mem_rv, 1'b0);

        // Starvation bound: M,M,M,M,I,M,M,M,M,I from a freshly reset counter
        for (int i = 0; i < 200 && obs_order.size() < 10; i++) begin
            step();
            if (e_mem_rv) pif.mem_addr += 32'd4;
            if (e_if_rv)  pif.if_addr += 32'd4;
        end
        chk("starve_count", obs_order.size(), 10);
        if (obs_order.size() >= 10) begin
            for (int k = 0; k < 10; k++) chk($sformatf("starve_order%0d", k), obs_order[k], pat[k]);
        end

        // Random traffic against the model
        sl_rand = 1'b1;
        for (int c = 0; c < 800; c++) begin
            step();
            if (pif.if_req) begin
                if (e_if_rv || pif.if_flush) begin
                    pif.if_req  = 1'($urandom_range(0, 1));
                    pif.if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                pif.if_req  = 1'b1;
                pif.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            pif.if_flush = ($urandom_range(0, 9) == 0);
            if (!pif.mem_req || e_mem_rv) begin
                pif.mem_req   = pif.mem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                pif.mem_we    = 1'($urandom_range(0, 1));
                pif.mem_be    = BW'($urandom);
                pif.mem_addr  = $urandom & 32'hFFFF_FFFC;
                pif.mem_wdata = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch (IF) and load/store (MEM) stages of the five-stage pipeline. Arbitrates one outstanding transaction at a time with MEM priority and bounded IF starvation, sequences the bus request/grant/response handshake, and returns per-requester valid and busy signals that feed the pipeline stall logic. An IF response whose fetch was flushed by a branch redirect is silently discarded.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_MEM_BURST, 4, consecutive MEM grants allowed while IF waits (≥1)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_rvalid or if_flush
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_flush  in  1  redirect: kill pending/outstanding fetch
- if_rvalid  out  1  fetch data valid (1 cycle)
- if_rdata  out  DATA_W  fetch data
- if_busy  out  1  if_req && !if_rvalid (IF stall)
- mem_req  in  1  load/store request; held until mem_rvalid
- mem_we  in  1  1 = store
- mem_be  in  DATA_W/8  byte enables
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_rvalid  out  1  load data / store completion (1 cycle)
- mem_rdata  out  DATA_W  load data
- mem_busy  out  1  mem_req && !mem_rvalid (MEM stall)
- bus_req  out  1  bus transaction request
- bus_we, bus_be, bus_addr, bus_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction fields
- bus_gnt  in  1  bus accepted request this cycle
- bus_rvalid  in  1  response (reads and writes)
- bus_rdata  in  DATA_W  response data

## Operation
- FSM: IDLE, WAIT_GNT, WAIT_RSP. Owner register: IF or MEM.
- IDLE: if any req, select winner, register bus fields and owner, assert bus_req, go WAIT_GNT. Otherwise stay.
- Selection: MEM wins if mem_req, unless starve_cnt == MAX_MEM_BURST and if_req, in which case IF wins. IF wins if only if_req.
- starve_cnt: increments on a MEM grant while if_req is high, saturating at MAX_MEM_BURST. Clears on an IF grant or whenever if_req is low.
- WAIT_GNT: bus_req and all bus fields are held stable. On bus_gnt, drop bus_req and go WAIT_RSP. bus_req is never withdrawn before bus_gnt, even on if_flush.
- WAIT_RSP: on bus_rvalid, pulse the owner's rvalid. Owner rdata = bus_rdata (combinational pass-through). Go IDLE.
- The non-owner's rvalid stays 0. Both rdata outputs may mirror bus_rdata at all times.
- Flush:
  - if_flush in WAIT_GNT or WAIT_RSP with owner IF sets drop. The transaction completes on the bus; if_rvalid is suppressed for it. drop clears on return to IDLE.
  - if_flush in the same cycle as the IF bus_rvalid also suppresses if_rvalid.
  - if_flush in IDLE with if_req high: IF is not eligible that cycle.
- Writes are only issued for owner MEM. IF transactions force bus_we=0 and bus_be all-ones.

## Timing
- Reset values: state IDLE, bus_req 0, bus fields 0, owner IF, drop 0, starve_cnt 0, if_rvalid 0, mem_rvalid 0.
- Reset mid-transaction abandons it immediately. The bus slave shares clk/rst and resets in the same cycle.
- Latency: request sampled at edge N, bus_req high in cycle N+1. With bus_gnt in N+1 and bus_rvalid in N+2, the owner rvalid pulses in N+2. Minimum 2 cycles from req to rvalid.
- Back-to-back: IDLE lasts one cycle between transactions. Throughput is at most 1 transaction per 3 cycles.
- if_busy and mem_busy are combinational from req and rvalid.

## Test plan
- Single IF fetch: if_req, addr 0x100; bus_gnt immediate, bus_rvalid next cycle, rdata 0x00000013 -> bus_req in cycle 1, if_rvalid=1 with if_rdata 0x00000013 in cycle 2, mem_rvalid=0 throughout.
- Simultaneous if_req and mem_req (load 0x2000) -> MEM granted first. IF granted in the next IDLE. if_busy stays high until IF's rvalid.
- Starvation: mem_req held continuously for 10 transactions, if_req held, MAX_MEM_BURST=4 -> grant order M,M,M,M,I,M,M,M,M,I.
- Store: mem_we=1, be=4'b0011, addr 0x40, wdata 0xDEADBEEF -> bus fields match exactly. mem_rvalid pulses on bus_rvalid. bus_we is never 1 for IF transactions.
- Flush during WAIT_RSP (owner IF) and flush coincident with bus_rvalid -> transaction completes, if_rvalid stays 0, FSM back in IDLE, next if_req served normally.
- rst asserted in WAIT_GNT with bus_gnt withheld -> next cycle bus_req=0, state IDLE, all outputs at reset values, starve_cnt 0.
